mem_port_arbiter: RTL and testbench

- Shares one single-ported 32-bit memory between the instruction-fetch stage (I port) and the load/store stage (D port).
- Serialises requests with at most one outstanding memory transaction.
- Gives data accesses priority, drops fetch results killed by a jump redirect, and tells the fetch stage when to hold its PC.
- Sits between the IF/MEM pipeline stages and the unified memory model.

---
 rtl/mem_port_arbiter_if.sv | 47 ++++
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between mem_port_arbiter, the IF/MEM pipeline stages and the unified memory.
// slave = arbiter view, master = view of the requesters and the memory model.
interface mem_port_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_kill;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        fetch_stall;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport slave (
        input  i_req, i_addr, i_kill,
        output i_gnt, i_rvalid, i_rdata, fetch_stall,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        output d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport master (
        output i_req, i_addr, i_kill,
        input  i_gnt, i_rvalid, i_rdata, fetch_stall,
        output d_req, d_we, d_addr, d_wdata, d_be,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch (I) and load/store (D), one transaction in flight.
// Define ARB_STARVE_GUARD_EN to force an I grant after STARVE_LIMIT back-to-back D grants.
module mem_port_arbiter
`ifdef ARB_STARVE_GUARD_EN
    #(parameter int unsigned STARVE_LIMIT = 4)
`endif
(
    input  logic              clk,
    input  logic              reset_n,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ISSUE_I, ISSUE_D, WAIT_I, WAIT_D} state_e;

    state_e      state_q, state_d;
    logic        kill_q, kill_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic        i_rvalid_q, i_rvalid_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic        d_rvalid_q, d_rvalid_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        i_gnt_c, d_gnt_c;
    logic        force_i;

`ifdef ARB_STARVE_GUARD_EN
    logic [2:0] starve_q, starve_d;

    assign force_i = ({29'd0, starve_q} >= STARVE_LIMIT) && bus.i_req;

    always_comb begin
        starve_d = starve_q;
        if (state_q == IDLE) begin
            if (i_gnt_c || !bus.i_req)
                starve_d = '0;
            else if (d_gnt_c && starve_q != 3'd7)
                starve_d = starve_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) starve_q <= '0;
        else          starve_q <= starve_d;
    end
`else
    assign force_i = 1'b0;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d     = state_q;
        kill_d      = kill_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        i_rvalid_d  = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rvalid_d  = 1'b0;
        d_rdata_d   = d_rdata_q;
        i_gnt_c     = 1'b0;
        d_gnt_c     = 1'b0;

        unique case (state_q)
            IDLE: begin
                kill_d = 1'b0;
                if (bus.d_req && !force_i) begin
                    d_gnt_c     = 1'b1;
                    state_d     = ISSUE_D;
                    mem_we_d    = bus.d_we;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                    mem_be_d    = bus.d_be;
                end else if (bus.i_req) begin
                    i_gnt_c     = 1'b1;
                    state_d     = ISSUE_I;
                    kill_d      = bus.i_kill;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.i_addr;
                    mem_wdata_d = '0;
                    mem_be_d    = 4'hF;
                end
            end
            ISSUE_I: begin
                if (bus.i_kill) kill_d = 1'b1;
                if (bus.mem_ready) state_d = WAIT_I;
            end
            ISSUE_D: begin
                if (bus.mem_ready) begin
                    if (mem_we_q) begin
                        state_d    = IDLE;
                        d_rvalid_d = 1'b1;
                        d_rdata_d  = '0;
                    end else begin
                        state_d = WAIT_D;
                    end
                end
            end
            WAIT_I: begin
                if (bus.mem_rvalid) begin
                    state_d = IDLE;
                    kill_d  = 1'b0;
                    // A redirect arriving with the data still makes the fetch stale.
                    if (!(kill_q || bus.i_kill)) begin
                        i_rvalid_d = 1'b1;
                        i_rdata_d  = bus.mem_rdata;
                    end
                end else if (bus.i_kill) begin
                    kill_d = 1'b1;
                end
            end
            WAIT_D: begin
                if (bus.mem_rvalid) begin
                    state_d    = IDLE;
                    d_rvalid_d = 1'b1;
                    d_rdata_d  = bus.mem_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            kill_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            i_rvalid_q  <= 1'b0;
            i_rdata_q   <= '0;
            d_rvalid_q  <= 1'b0;
            d_rdata_q   <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            state_q     <= state_d;
            kill_q      <= kill_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            i_rvalid_q  <= i_rvalid_d;
            i_rdata_q   <= i_rdata_d;
            d_rvalid_q  <= d_rvalid_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    // Grants are combinational from IDLE, so they must be masked while reset is held.
    assign bus.i_gnt       = i_gnt_c & reset_n;
    assign bus.d_gnt       = d_gnt_c & reset_n;
    assign bus.i_rvalid    = i_rvalid_q;
    assign bus.i_rdata     = i_rdata_q;
    assign bus.d_rvalid    = d_rvalid_q;
    assign bus.d_rdata     = d_rdata_q;
    assign bus.mem_req     = (state_q == ISSUE_I) || (state_q == ISSUE_D);
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.mem_be      = mem_be_q;
    assign bus.fetch_stall = ((bus.i_req & ~bus.i_gnt) | (state_q == ISSUE_I) | (state_q == WAIT_I))
                             & ~i_rvalid_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random-stimulus bench for mem_port_arbiter against a transaction-level reference model.
// Honours ARB_STARVE_GUARD_EN the same way as the design (STARVE_LIMIT default 4).
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus();
    mem_port_arbiter dut (.clk(clk), .reset_n(reset_n), .bus(bus));

`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    localparam int LIMIT = 4;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction described by what it is and how far it got.
    bit          m_busy, m_is_i, m_we, m_accepted, m_killed;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;
    bit          m_i_rvalid, m_d_rvalid;
    logic [31:0] m_i_rdata, m_d_rdata;
    int          m_starve;

    task automatic model_reset();
        m_busy = 0; m_is_i = 0; m_we = 0; m_accepted = 0; m_killed = 0;
        m_addr = '0; m_wdata = '0; m_be = '0;
        m_i_rvalid = 0; m_d_rvalid = 0;
        m_i_rdata = '0; m_d_rdata = '0;
        m_starve = 0;
    endtask

    // mode 0: mixed traffic, 1: both requesters held high, 2: frequent redirects
    task automatic drive(input int mode);
        bus.i_req      = (mode == 1) ? 1'b1 : ($urandom_range(0, 99) < 60);
        bus.i_addr     = $urandom & 32'hFFFF_FFFC;
        bus.i_kill     = (mode == 2) ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 8);
        bus.d_req      = (mode == 1) ? 1'b1 : ($urandom_range(0, 99) < 40);
        bus.d_we       = 1'($urandom_range(0, 1));
        bus.d_addr     = $urandom;
        bus.d_wdata    = $urandom;
        bus.d_be       = 4'($urandom_range(0, 15));
        bus.mem_ready  = ($urandom_range(0, 99) < 55);
        bus.mem_rvalid = (m_busy && m_accepted) ? ($urandom_range(0, 99) < 50)
                                                : ($urandom_range(0, 99) < 15);
        bus.mem_rdata  = $urandom;
    endtask

    task automatic cycle(input int mode);
        bit e_i_gnt, e_d_gnt, e_force, e_stall, e_mem_req, n_i_rv, n_d_rv;
        @(negedge clk);
        drive(mode);
        #1;
        e_force   = GUARD && (m_starve >= LIMIT) && bus.i_req;
        e_d_gnt   = !m_busy && bus.d_req && !e_force;
        e_i_gnt   = !m_busy && bus.i_req && !e_d_gnt;
        e_stall   = !m_i_rvalid && ((bus.i_req && !e_i_gnt) || (m_busy && m_is_i));
        e_mem_req = m_busy && !m_accepted;

        check("i_gnt", bus.i_gnt, e_i_gnt);
        check("d_gnt", bus.d_gnt, e_d_gnt);
        check("fetch_stall", bus.fetch_stall, e_stall);
        check("mem_req", bus.mem_req, e_mem_req);
        check("i_rvalid", bus.i_rvalid, m_i_rvalid);
        check("d_rvalid", bus.d_rvalid, m_d_rvalid);
        check("d_rdata", bus.d_rdata, m_d_rdata);
        if (m_i_rvalid) check("i_rdata", bus.i_rdata, m_i_rdata);
        if (e_mem_req) begin
            check("mem_addr", bus.mem_addr, m_addr);
            check("mem_we", bus.mem_we, m_we);
            if (m_we) begin
                check("mem_wdata", bus.mem_wdata, m_wdata);
                check("mem_be", bus.mem_be, m_be);
            end
        end

        n_i_rv = 0;
        n_d_rv = 0;
        if (!m_busy) begin
            if (e_d_gnt) begin
                m_busy = 1; m_is_i = 0; m_we = bus.d_we; m_addr = bus.d_addr;
                m_wdata = bus.d_wdata; m_be = bus.d_be; m_accepted = 0; m_killed = 0;
            end else if (e_i_gnt) begin
                m_busy = 1; m_is_i = 1; m_we = 0; m_addr = bus.i_addr;
                m_accepted = 0; m_killed = bus.i_kill;
            end
            if (e_i_gnt || !bus.i_req) m_starve = 0;
            else if (e_d_gnt && m_starve < 7) m_starve++;
        end else begin
            if (m_is_i && bus.i_kill) m_killed = 1;
            if (!m_accepted) begin
                if (bus.mem_ready) begin
                    if (m_we) begin
                        m_busy = 0; n_d_rv = 1; m_d_rdata = '0;
                    end else begin
                        m_accepted = 1;
                    end
                end
            end else if (bus.mem_rvalid) begin
                m_busy = 0;
                if (m_is_i) begin
                    if (!m_killed) begin
                        n_i_rv = 1; m_i_rdata = bus.mem_rdata;
                    end
                end else begin
                    n_d_rv = 1; m_d_rdata = bus.mem_rdata;
                end
            end
        end
        m_i_rvalid = n_i_rv;
        m_d_rvalid = n_d_rv;
    endtask

    task automatic check_reset_outputs(input string where);
        check({where, "_mem_req"}, bus.mem_req, 0);
        check({where, "_mem_we"}, bus.mem_we, 0);
        check({where, "_mem_addr"}, bus.mem_addr, 0);
        check({where, "_mem_wdata"}, bus.mem_wdata, 0);
        check({where, "_mem_be"}, bus.mem_be, 0);
        check({where, "_i_gnt"}, bus.i_gnt, 0);
        check({where, "_d_gnt"}, bus.d_gnt, 0);
        check({where, "_i_rvalid"}, bus.i_rvalid, 0);
        check({where, "_d_rvalid"}, bus.d_rvalid, 0);
        check({where, "_i_rdata"}, bus.i_rdata, 0);
        check({where, "_d_rdata"}, bus.d_rdata, 0);
        check({where, "_fetch_stall"}, bus.fetch_stall, bus.i_req);
    endtask

    initial begin
        int tries;
        reset_n = 1'b0;
        model_reset();
        bus.i_req = 1'b1; bus.i_addr = 32'h40; bus.i_kill = 1'b0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100; bus.d_wdata = '0; bus.d_be = 4'hF;
        bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        #2;
        check_reset_outputs("por");
        check("por_stall_follows_i_req", bus.fetch_stall, 1);

        @(negedge clk);
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        reset_n   = 1'b1;

        repeat (1500) cycle(0);
        repeat (150)  cycle(1);
        repeat (600)  cycle(2);

        // Reach a load waiting for its data, then pull reset underneath it.
        tries = 0;
        while (!(m_busy && !m_is_i && m_accepted) && tries < 3000) begin
            cycle(0);
            tries++;
        end
        check("reach_wait_d", tries < 3000, 1);
        @(negedge clk);
        bus.i_req = 1'b0; bus.d_req = 1'b0; bus.i_kill = 1'b0;
        bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check_reset_outputs("mid");
        @(negedge clk);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hCAFE_F00D;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check("late_rvalid_ignored", bus.d_rvalid, 0);
        check("late_mem_req", bus.mem_req, 0);
        check("late_d_rdata", bus.d_rdata, 0);

        repeat (400) cycle(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
